// File: rtl/mem_arb_pkg.sv
// Shared types, defaults and the round-robin pick used by the memory bus arbiter.
package mem_arb_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_ACC  = 2'd1,
        HOST_ACC = 2'd2
    } arbstate;

    typedef enum logic {
        REQ_CPU  = 1'b0,
        REQ_HOST = 1'b1
    } requester;

    // A lone requester wins; on a conflict the one not served last wins.
    function automatic requester pick_winner(input logic     cpu_req,
                                             input logic     host_req,
                                             input requester last);
        if (cpu_req && host_req)
            return (last == REQ_CPU) ? REQ_HOST : REQ_CPU;
        else if (cpu_req)
            return REQ_CPU;
        else
            return REQ_HOST;
    endfunction

endpackage

// File: rtl/arb_timer.sv
// Wait counter for one external access; expired_o flags the last permitted
// cycle without an acknowledge so the arbiter can abort on that edge.
module arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != LAST))
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // cnt_q counts completed wait cycles, so LAST marks the TIMEOUT-th strobe cycle.
    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a CPU port and a host/loader port onto one external memory bus,
// round-robin on conflict, with a bounded wait for the memory acknowledge.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_memread,
    input  logic             cpu_memwrite,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_writedata,
    output logic             cpu_stall,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [WIDTH-1:0] host_adr,
    input  logic [WIDTH-1:0] host_wdata,
    output logic             host_done,
    output logic             host_err,
    output logic [WIDTH-1:0] host_rdata,
    output logic             ext_re,
    output logic             ext_we,
    output logic [WIDTH-1:0] ext_adr,
    output logic [WIDTH-1:0] ext_wdata,
    input  logic [WIDTH-1:0] ext_rdata,
    input  logic             ext_ack
);

    arbstate          state_q, state_d;
    requester         last_q, last_d;
    logic             ext_re_q, ext_re_d;
    logic             ext_we_q, ext_we_d;
    logic [WIDTH-1:0] ext_adr_q, ext_adr_d;
    logic [WIDTH-1:0] ext_wdata_q, ext_wdata_d;
    logic [WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [WIDTH-1:0] host_rdata_q, host_rdata_d;
    logic             host_done_q, host_done_d;
    logic             host_err_q, host_err_d;

    logic             cpu_req;
    logic             in_acc;
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_expired;
    requester         winner;

    assign cpu_req = cpu_memread | cpu_memwrite;
    assign in_acc  = (state_q != IDLE);
    assign tmr_en  = in_acc && !ext_ack;
    assign winner  = pick_winner(cpu_req, host_req, last_q);

    arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        ext_re_d     = ext_re_q;
        ext_we_d     = ext_we_q;
        ext_adr_d    = ext_adr_q;
        ext_wdata_d  = ext_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;
        host_done_d  = 1'b0;
        host_err_d   = 1'b0;
        tmr_clr      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req || host_req) begin
                    tmr_clr = 1'b1;
                    if (winner == REQ_CPU) begin
                        state_d     = CPU_ACC;
                        ext_we_d    = cpu_memwrite;
                        ext_re_d    = !cpu_memwrite;
                        ext_adr_d   = cpu_adr;
                        ext_wdata_d = cpu_writedata;
                    end else begin
                        state_d     = HOST_ACC;
                        ext_we_d    = host_we;
                        ext_re_d    = !host_we;
                        ext_adr_d   = host_adr;
                        ext_wdata_d = host_wdata;
                    end
                end
            end

            CPU_ACC, HOST_ACC: begin
                // An acknowledge arriving on the expiry cycle still completes normally.
                if (ext_ack || tmr_expired) begin
                    state_d  = IDLE;
                    ext_re_d = 1'b0;
                    ext_we_d = 1'b0;
                    tmr_clr  = 1'b1;
                    if (state_q == CPU_ACC) begin
                        last_d      = REQ_CPU;
                        cpu_rdata_d = ext_ack ? ext_rdata : '1;
                    end else begin
                        last_d = REQ_HOST;
                        if (ext_ack) begin
                            host_rdata_d = ext_rdata;
                            host_done_d  = 1'b1;
                        end else begin
                            host_err_d = 1'b1;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= REQ_HOST;
            ext_re_q     <= 1'b0;
            ext_we_q     <= 1'b0;
            ext_adr_q    <= '0;
            ext_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
            host_done_q  <= 1'b0;
            host_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            ext_re_q     <= ext_re_d;
            ext_we_q     <= ext_we_d;
            ext_adr_q    <= ext_adr_d;
            ext_wdata_q  <= ext_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
            host_done_q  <= host_done_d;
            host_err_q   <= host_err_d;
        end
    end

    // The CPU is released on the completing cycle, whether acknowledged or timed out.
    assign cpu_stall  = cpu_req && !((state_q == CPU_ACC) && (ext_ack || tmr_expired));

    assign cpu_rdata  = cpu_rdata_q;
    assign host_rdata = host_rdata_q;
    assign host_done  = host_done_q;
    assign host_err   = host_err_q;
    assign ext_re     = ext_re_q;
    assign ext_we     = ext_we_q;
    assign ext_adr    = ext_adr_q;
    assign ext_wdata  = ext_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: reset, table vectors, corner sequences
// and randomized traffic against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cpu_memread = 1'b0;
    logic             cpu_memwrite = 1'b0;
    logic [WIDTH-1:0] cpu_adr = '0;
    logic [WIDTH-1:0] cpu_writedata = '0;
    logic             cpu_stall;
    logic [WIDTH-1:0] cpu_rdata;
    logic             host_req = 1'b0;
    logic             host_we = 1'b0;
    logic [WIDTH-1:0] host_adr = '0;
    logic [WIDTH-1:0] host_wdata = '0;
    logic             host_done;
    logic             host_err;
    logic [WIDTH-1:0] host_rdata;
    logic             ext_re;
    logic             ext_we;
    logic [WIDTH-1:0] ext_adr;
    logic [WIDTH-1:0] ext_wdata;
    logic [WIDTH-1:0] ext_rdata = '0;
    logic             ext_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    logic       cpu_pend, host_pend;
    logic       m_cpu_we, m_host_we;
    logic [7:0] m_cpu_adr, m_cpu_wd, m_host_adr, m_host_wd;
    logic [7:0] m_cpu_rdata, m_host_rdata;
    int         m_last;   // 0 = CPU served last, 1 = host served last
    int         k_r, lat_r, n_r;

    typedef struct {
        logic       is_cpu;
        logic       rd;
        logic       wr;
        logic [7:0] adr;
        logic [7:0] wd;
        int         lat;
        logic [7:0] rdata;
        logic       exp_we;
        int         exp_hi;
        logic [7:0] exp_res;
        logic       exp_ok;
    } vec_t;

    vec_t tbl[7];

    mem_bus_arbiter #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_memread   (cpu_memread),
        .cpu_memwrite  (cpu_memwrite),
        .cpu_adr       (cpu_adr),
        .cpu_writedata (cpu_writedata),
        .cpu_stall     (cpu_stall),
        .cpu_rdata     (cpu_rdata),
        .host_req      (host_req),
        .host_we       (host_we),
        .host_adr      (host_adr),
        .host_wdata    (host_wdata),
        .host_done     (host_done),
        .host_err      (host_err),
        .host_rdata    (host_rdata),
        .ext_re        (ext_re),
        .ext_we        (ext_we),
        .ext_adr       (ext_adr),
        .ext_wdata     (ext_wdata),
        .ext_rdata     (ext_rdata),
        .ext_ack       (ext_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cpu_request(input logic rd, input logic wr, input logic [7:0] adr, input logic [7:0] wd);
        cpu_memread   = rd;
        cpu_memwrite  = wr;
        cpu_adr       = adr;
        cpu_writedata = wd;
        cpu_pend      = 1'b1;
        m_cpu_we      = wr;
        m_cpu_adr     = adr;
        m_cpu_wd      = wd;
    endtask

    task automatic host_request(input logic we, input logic [7:0] adr, input logic [7:0] wd);
        host_req   = 1'b1;
        host_we    = we;
        host_adr   = adr;
        host_wdata = wd;
        host_pend  = 1'b1;
        m_host_we  = we;
        m_host_adr = adr;
        m_host_wd  = wd;
    endtask

    // Plays the memory side of one access; called at a falling edge.
    // lat = strobe cycle in which ext_ack is given (beyond TIMEOUT means never).
    task automatic run_access(input logic who_cpu, input logic exp_we, input logic [7:0] exp_adr,
                              input logic [7:0] exp_wd, input int lat, input logic [7:0] rd,
                              input int exp_hi, input logic [7:0] exp_res, input logic exp_ok);
        int   n;
        int   hi;
        logic bad;
        logic done_c;
        n   = 0;
        hi  = 0;
        bad = 1'b0;
        while (!(ext_re || ext_we) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("grant_seen", 32'(ext_re || ext_we), 1);
        check("ext_we", 32'(ext_we), 32'(exp_we));
        check("ext_re", 32'(ext_re), 32'(!exp_we));
        check("ext_adr", 32'(ext_adr), 32'(exp_adr));
        check("ext_wdata", 32'(ext_wdata), 32'(exp_wd));
        for (int c = 1; c <= TIMEOUT + 2; c++) begin
            if (!(ext_re || ext_we)) break;
            hi++;
            if (ext_adr !== exp_adr || ext_wdata !== exp_wd || ext_we !== exp_we || ext_re !== !exp_we)
                bad = 1'b1;
            done_c = (c == lat) || (c == TIMEOUT);
            if (c == lat) begin
                ext_ack   = 1'b1;
                ext_rdata = rd;
            end
            #1;
            check("cpu_stall", 32'(cpu_stall), 32'(cpu_pend && !(who_cpu && done_c)));
            @(posedge clk);
            #1;
            ext_ack   = 1'b0;
            ext_rdata = 8'($urandom);
            if (!who_cpu && c == 1) begin
                host_req  = 1'b0;
                host_pend = 1'b0;
            end
            if (who_cpu && done_c) begin
                cpu_memread  = 1'b0;
                cpu_memwrite = 1'b0;
                cpu_pend     = 1'b0;
            end
            @(negedge clk);
        end
        check("strobe_cycles", 32'(hi), 32'(exp_hi));
        check("strobes_held", 32'(bad), 0);
        if (who_cpu) begin
            m_cpu_rdata = exp_res;
            check("host_done_on_cpu", 32'({host_done, host_err}), 0);
        end else begin
            if (exp_ok) m_host_rdata = exp_res;
            check("host_done", 32'(host_done), 32'(exp_ok));
            check("host_err", 32'(host_err), 32'(!exp_ok));
        end
        check("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rdata));
        check("host_rdata", 32'(host_rdata), 32'(m_host_rdata));
        m_last = who_cpu ? 0 : 1;
        @(posedge clk);
        @(negedge clk);
        check("pulse_once", 32'({host_done, host_err}), 0);
    endtask

    // Predicts the next served requester from the pending set and last grant.
    task automatic serve_next(input int lat);
        logic       who;
        logic       ok;
        logic [7:0] rd;
        who = cpu_pend && (!host_pend || m_last == 1);
        ok  = (lat <= TIMEOUT);
        rd  = 8'($urandom);
        run_access(who, who ? m_cpu_we : m_host_we, who ? m_cpu_adr : m_host_adr,
                   who ? m_cpu_wd : m_host_wd, lat, rd, ok ? lat : TIMEOUT,
                   ok ? rd : (who ? 8'hFF : m_host_rdata), ok);
    endtask

    initial begin
        //          cpu   rd    wr    adr    wd     lat rdata  we    hi  res    ok
        tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h05, 8'h00, 4,  8'hA7, 1'b0, 4,  8'hA7, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 8'h06, 8'h55, 2,  8'h11, 1'b1, 2,  8'h11, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h10, 8'h3C, 99, 8'h00, 1'b1, 15, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h82, 8'h00, 1,  8'h5A, 1'b0, 1,  8'h5A, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h07, 8'hC3, 20, 8'h00, 1'b1, 15, 8'hFF, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 8'h83, 8'h00, 15, 8'h6B, 1'b0, 15, 8'h6B, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h08, 8'h00, 16, 8'h00, 1'b0, 15, 8'hFF, 1'b0};

        cpu_pend     = 1'b0;
        host_pend    = 1'b0;
        m_cpu_we     = 1'b0;
        m_host_we    = 1'b0;
        m_cpu_adr    = '0;
        m_cpu_wd     = '0;
        m_host_adr   = '0;
        m_host_wd    = '0;
        m_cpu_rdata  = '0;
        m_host_rdata = '0;
        m_last       = 1;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_strobes", 32'({ext_re, ext_we}), 0);
        check("rst_ext_adr", 32'(ext_adr), 0);
        check("rst_ext_wdata", 32'(ext_wdata), 0);
        check("rst_rdata", 32'({cpu_rdata, host_rdata}), 0);
        check("rst_pulses", 32'({host_done, host_err}), 0);
        check("rst_stall", 32'(cpu_stall), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Simultaneous requests after reset: CPU first, then host
        cpu_request(1'b1, 1'b0, 8'h21, 8'h00);
        host_request(1'b0, 8'h91, 8'h00);
        run_access(1'b1, 1'b0, 8'h21, 8'h00, 2, 8'h42, 2, 8'h42, 1'b1);
        run_access(1'b0, 1'b0, 8'h91, 8'h00, 3, 8'h24, 3, 8'h24, 1'b1);

        // Single-requester vectors
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].is_cpu)
                cpu_request(tbl[i].rd, tbl[i].wr, tbl[i].adr, tbl[i].wd);
            else
                host_request(tbl[i].wr, tbl[i].adr, tbl[i].wd);
            run_access(tbl[i].is_cpu, tbl[i].exp_we, tbl[i].adr, tbl[i].wd, tbl[i].lat,
                       tbl[i].rdata, tbl[i].exp_hi, tbl[i].exp_res, tbl[i].exp_ok);
        end

        // Acknowledge while idle must be ignored
        ext_ack   = 1'b1;
        ext_rdata = 8'h99;
        @(posedge clk);
        #1 ext_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_strobes", 32'({ext_re, ext_we}), 0);
        check("idle_ack_pulses", 32'({host_done, host_err}), 0);
        check("idle_ack_rdata", 32'({cpu_rdata, host_rdata}), 32'({m_cpu_rdata, m_host_rdata}));

        // Back-to-back requests from both sides alternate with one idle cycle
        host_request(1'b0, 8'hA0, 8'h00);
        cpu_request(1'b1, 1'b0, 8'h30, 8'h00);
        for (int i = 0; i < 4; i++) begin
            serve_next(2 + i);
            check("rr_one_idle_gap", 32'(ext_re || ext_we), 1);
            if (m_last == 0)
                cpu_request(1'b1, 1'b0, 8'(8'h31 + i), 8'h00);
            else
                host_request(1'b0, 8'(8'hA1 + i), 8'h00);
        end
        serve_next(3);

        // Reset in the middle of a CPU access
        cpu_request(1'b1, 1'b0, 8'h44, 8'h00);
        n_r = 0;
        while (!ext_re && n_r < 5) begin
            @(negedge clk);
            n_r++;
        end
        check("mid_rst_started", 32'(ext_re), 1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_strobes", 32'({ext_re, ext_we}), 0);
        check("mid_rst_ext_adr", 32'(ext_adr), 0);
        check("mid_rst_rdata", 32'({cpu_rdata, host_rdata}), 0);
        cpu_memread  = 1'b0;
        cpu_pend     = 1'b0;
        m_cpu_rdata  = '0;
        m_host_rdata = '0;
        m_last       = 1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        ext_ack   = 1'b1;
        ext_rdata = 8'hEE;
        @(posedge clk);
        #1 ext_ack = 1'b0;
        @(negedge clk);
        check("late_ack_strobes", 32'({ext_re, ext_we}), 0);
        check("late_ack_cpu_rdata", 32'(cpu_rdata), 0);
        check("late_ack_pulses", 32'({host_done, host_err}), 0);

        // Randomized traffic against the model
        for (int r = 0; r < 60; r++) begin
            if (!cpu_pend && $urandom_range(0, 3) != 0) begin
                k_r = $urandom_range(1, 3);
                cpu_request(k_r[0], k_r[1], 8'($urandom_range(0, 127)), 8'($urandom));
            end
            if (!host_pend && $urandom_range(0, 3) != 0)
                host_request(1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)), 8'($urandom));
            if (!cpu_pend && !host_pend)
                host_request(1'b0, 8'($urandom_range(128, 255)), 8'h00);
            lat_r = $urandom_range(1, TIMEOUT + 3);
            serve_next(lat_r);
        end
        while (cpu_pend || host_pend) serve_next(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
